// File: rtl/osc_acq_seg.sv
// osc_acq_seg: segmented pre/post-trigger acquisition gate.
// Passes DN-lane beats from sti to a one-deep registered sto stage while a
// record is open, counts pre/post beats, timestamps accepted triggers and
// inserts a holdoff between records.
//
//   state | meaning
//   IDLE  | stopped; input beats discarded
//   PRE   | passing pre-trigger beats until cfg_pre have been seen
//   ARM   | still passing pre beats; waiting for ctl_trg
//   POST  | passing post-trigger beats until the record is complete
//   HOLD  | holdoff between records; input beats discarded
module osc_acq_seg #(
    parameter int DN = 2,
    parameter int DW = 16,
    parameter int CW = 31,
    parameter int SW = 16,
    parameter int HW = 24,
    parameter int TW = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DN*DW-1:0] sti_tdata,
    input  logic             sti_tvalid,
    output logic             sti_tready,
    output logic [DN*DW-1:0] sto_tdata,
    output logic             sto_tvalid,
    output logic             sto_tlast,
    input  logic             sto_tready,
    input  logic             ctl_rst,
    input  logic             ctl_str,
    input  logic             ctl_stp,
    input  logic             ctl_trg,
    input  logic [CW-1:0]    cfg_pre,
    input  logic [CW-1:0]    cfg_pst,
    input  logic [SW-1:0]    cfg_seg,
    input  logic [HW-1:0]    cfg_hld,
    output logic             sts_run,
    output logic [CW-1:0]    sts_pre,
    output logic             sts_pro,
    output logic [CW-1:0]    sts_pst,
    output logic [SW-1:0]    sts_seg,
    output logic [TW-1:0]    sts_tst,
    output logic             sts_trg,
    output logic             evn_lst
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PRE  = 3'd1,
        S_ARM  = 3'd2,
        S_POST = 3'd3,
        S_HOLD = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    pre_q, pre_d;
    logic             pro_q, pro_d;
    logic [CW-1:0]    pst_q, pst_d;
    logic [SW-1:0]    seg_q, seg_d;
    logic [HW-1:0]    hld_q, hld_d;
    logic [TW-1:0]    ts_q, ts_d;
    logic [TW-1:0]    tst_q, tst_d;
    logic             trg_q, trg_d;
    logic             evn_q, evn_d;
    logic [DN*DW-1:0] odat_q, odat_d;
    logic             oval_q, oval_d;
    logic             olst_q, olst_d;

    logic             win;
    logic             beat_load;
    logic [CW-1:0]    pst_tgt;
    logic             rec_end;
    logic [SW-1:0]    seg_inc;
    logic             seg_fin;

    // A stop or soft reset closes the window in the same cycle, so the beat
    // offered alongside it is discarded rather than half-counted.
    assign win = ((state_q == S_PRE) || (state_q == S_ARM) || (state_q == S_POST))
                 & ~ctl_stp & ~ctl_rst & ~rst;
    assign sti_tready = win ? (~oval_q | sto_tready) : 1'b1;
    assign beat_load  = win & sti_tvalid & sti_tready;

    // A zero post length still produces a one-beat record.
    assign pst_tgt = (cfg_pst == '0) ? CW'(1) : cfg_pst;
    assign rec_end = (state_q == S_POST) & beat_load & (pst_q == pst_tgt - CW'(1));
    assign seg_inc = seg_q + SW'(1);
    assign seg_fin = (cfg_seg != '0) & (seg_inc == cfg_seg);

    // Next-state, counters and status; priority ctl_rst > ctl_stp > start > trigger.
    always_comb begin
        state_d = state_q;
        pre_d   = pre_q;
        pro_d   = pro_q;
        pst_d   = pst_q;
        seg_d   = seg_q;
        hld_d   = hld_q;
        ts_d    = ts_q + TW'(1);
        tst_d   = tst_q;
        trg_d   = 1'b0;
        evn_d   = 1'b0;
        if (ctl_rst) begin
            state_d = S_IDLE;
            pre_d   = '0;
            pro_d   = 1'b0;
            pst_d   = '0;
            seg_d   = '0;
            hld_d   = '0;
            ts_d    = '0;
            tst_d   = '0;
        end else if (ctl_stp) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (ctl_str) begin
                        state_d = S_PRE;
                        pre_d   = '0;
                        pro_d   = 1'b0;
                        pst_d   = '0;
                        seg_d   = '0;
                        ts_d    = '0;
                    end
                end
                S_PRE, S_ARM: begin
                    if (beat_load) begin
                        if (!(&pre_q)) pre_d = pre_q + CW'(1);
                        if (&pre_d) pro_d = 1'b1;
                    end
                    if (state_q == S_PRE) begin
                        if (pre_q >= cfg_pre) state_d = S_ARM;
                    end else if (ctl_trg) begin
                        state_d = S_POST;
                        trg_d   = 1'b1;
                        tst_d   = ts_q;
                    end
                end
                S_POST: begin
                    if (beat_load) begin
                        pst_d = pst_q + CW'(1);
                        if (rec_end) begin
                            seg_d = seg_inc;
                            if (seg_fin) begin
                                state_d = S_IDLE;
                                evn_d   = 1'b1;
                            end else begin
                                state_d = S_HOLD;
                                hld_d   = cfg_hld;
                            end
                        end
                    end
                end
                S_HOLD: begin
                    if (hld_q == '0) begin
                        state_d = S_PRE;
                        pre_d   = '0;
                        pro_d   = 1'b0;
                        pst_d   = '0;
                    end else begin
                        hld_d = hld_q - HW'(1);
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // One-deep output stage: load on an accepted in-window beat, else drain.
    always_comb begin
        odat_d = odat_q;
        oval_d = oval_q;
        olst_d = olst_q;
        if (beat_load) begin
            odat_d = sti_tdata;
            oval_d = 1'b1;
            olst_d = rec_end;
        end else if (sto_tready) begin
            oval_d = 1'b0;
            olst_d = 1'b0;
        end
        if (ctl_rst) begin
            oval_d = 1'b0;
            olst_d = 1'b0;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            pre_q   <= '0;
            pro_q   <= 1'b0;
            pst_q   <= '0;
            seg_q   <= '0;
            hld_q   <= '0;
            ts_q    <= '0;
            tst_q   <= '0;
            trg_q   <= 1'b0;
            evn_q   <= 1'b0;
            odat_q  <= '0;
            oval_q  <= 1'b0;
            olst_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pre_q   <= pre_d;
            pro_q   <= pro_d;
            pst_q   <= pst_d;
            seg_q   <= seg_d;
            hld_q   <= hld_d;
            ts_q    <= ts_d;
            tst_q   <= tst_d;
            trg_q   <= trg_d;
            evn_q   <= evn_d;
            odat_q  <= odat_d;
            oval_q  <= oval_d;
            olst_q  <= olst_d;
        end
    end

    assign sto_tdata  = odat_q;
    assign sto_tvalid = oval_q;
    assign sto_tlast  = olst_q;
    assign sts_run    = (state_q != S_IDLE);
    assign sts_pre    = pre_q;
    assign sts_pro    = pro_q;
    assign sts_pst    = pst_q;
    assign sts_seg    = seg_q;
    assign sts_tst    = tst_q;
    assign sts_trg    = trg_q;
    assign evn_lst    = evn_q;

endmodule
